// File: rtl/afe_pulser_if.sv
// Shared bus width constants for the AFE pulser sequencer.
package afe_pulser_pkg;
    localparam int unsigned WIDTH_W  = 16;
    localparam int unsigned PERIOD_W = 24;
    localparam int unsigned COUNT_W  = 16;
endpackage

// File: rtl/afe_pulser_seq_if.sv
// Request/config and pulser-facing signals of the AFE pulser sequencer.
interface afe_pulser_seq_if;
    import afe_pulser_pkg::*;

    logic                start;
    logic                single;
    logic                stop;
    logic [WIDTH_W-1:0]  cfg_width;
    logic [PERIOD_W-1:0] cfg_period;
    logic [COUNT_W-1:0]  cfg_count;
    logic                io_rst;
    logic                trig;
    logic [WIDTH_W-1:0]  width;
    logic                busy;
    logic                done;
    logic                err;
    logic [COUNT_W-1:0]  pulse_cnt;

    modport master (
        output start, single, stop, cfg_width, cfg_period, cfg_count,
        input  io_rst, trig, width, busy, done, err, pulse_cnt
    );

    modport slave (
        input  start, single, stop, cfg_width, cfg_period, cfg_count,
        output io_rst, trig, width, busy, done, err, pulse_cnt
    );
endinterface

// File: rtl/afe_pulser_seq.sv
// Burst sequencer for the AFE pulser: io_rst hold after reset, then trig bursts
// with latched width/period/count, stop/abort handling and status outputs.
module afe_pulser_seq
    import afe_pulser_pkg::*;
#(
    parameter int unsigned IO_RST_CYCLES = 10,
    parameter int unsigned MIN_PERIOD    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    afe_pulser_seq_if.slave  bus
);

    localparam int unsigned HOLD_W = (IO_RST_CYCLES > 1) ? $clog2(IO_RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(IO_RST_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);

    typedef enum logic [2:0] {
        S_IO_HOLD = 3'd0,
        S_IDLE    = 3'd1,
        S_FIRE    = 3'd2,
        S_WAIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic [HOLD_W-1:0]   r_hold,      w_hold_nxt;
    logic [WIDTH_W-1:0]  r_width,     w_width_nxt;
    logic [PERIOD_W-1:0] r_period,    w_period_nxt;
    logic [COUNT_W-1:0]  r_count,     w_count_nxt;
    logic [COUNT_W-1:0]  r_burst,     w_burst_nxt;
    logic [COUNT_W-1:0]  r_pulse_cnt, w_pulse_cnt_nxt;
    logic [PERIOD_W-1:0] r_wait,      w_wait_nxt;
    logic                r_io_rst,    w_io_rst_nxt;
    logic                r_trig,      w_trig_nxt;
    logic                r_busy,      w_busy_nxt;
    logic                r_done,      w_done_nxt;
    logic                r_err,       w_err_nxt;
    logic [COUNT_W-1:0]  w_burst_inc;
    logic [COUNT_W-1:0]  w_pulse_inc;

    // Wrapping burst counter decides completion; the reported count saturates.
    assign w_burst_inc = r_burst + COUNT_W'(1);
    assign w_pulse_inc = (r_pulse_cnt == '1) ? r_pulse_cnt : r_pulse_cnt + COUNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IO_HOLD;
            r_hold      <= '0;
            r_width     <= '0;
            r_period    <= '0;
            r_count     <= '0;
            r_burst     <= '0;
            r_pulse_cnt <= '0;
            r_wait      <= '0;
            r_io_rst    <= 1'b1;
            r_trig      <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_width     <= w_width_nxt;
            r_period    <= w_period_nxt;
            r_count     <= w_count_nxt;
            r_burst     <= w_burst_nxt;
            r_pulse_cnt <= w_pulse_cnt_nxt;
            r_wait      <= w_wait_nxt;
            r_io_rst    <= w_io_rst_nxt;
            r_trig      <= w_trig_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold;
        w_width_nxt     = r_width;
        w_period_nxt    = r_period;
        w_count_nxt     = r_count;
        w_burst_nxt     = r_burst;
        w_pulse_cnt_nxt = r_pulse_cnt;
        w_wait_nxt      = r_wait;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            S_IO_HOLD: begin
                if (r_hold == HOLD_LAST) w_state_nxt = S_IDLE;
                else                     w_hold_nxt  = r_hold + HOLD_W'(1);
            end
            S_IDLE: begin
                if (!bus.stop && (bus.start || bus.single)) begin
                    if (bus.cfg_width == '0) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_width_nxt     = bus.cfg_width;
                        w_period_nxt    = (bus.cfg_period < MIN_P) ? MIN_P : bus.cfg_period;
                        w_count_nxt     = bus.start ? bus.cfg_count : COUNT_W'(1);
                        w_burst_nxt     = '0;
                        w_pulse_cnt_nxt = '0;
                        w_state_nxt     = S_FIRE;
                    end
                end
            end
            S_FIRE: begin
                w_burst_nxt     = w_burst_inc;
                w_pulse_cnt_nxt = w_pulse_inc;
                w_wait_nxt      = '0;
                if (bus.stop || ((r_count != '0) && (w_burst_inc == r_count)))
                    w_state_nxt = S_DONE;
                else
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // FIRE plus (period-1) WAIT cycles gives trig-to-trig = period.
                if (bus.stop)                                   w_state_nxt = S_DONE;
                else if (r_wait == r_period - PERIOD_W'(2))     w_state_nxt = S_FIRE;
                else                                            w_wait_nxt  = r_wait + PERIOD_W'(1);
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IO_HOLD;
        endcase

        w_io_rst_nxt = (w_state_nxt == S_IO_HOLD);
        w_trig_nxt   = (w_state_nxt == S_FIRE);
        w_busy_nxt   = (w_state_nxt != S_IDLE);
    end

    assign bus.io_rst    = r_io_rst;
    assign bus.trig      = r_trig;
    assign bus.width     = r_width;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_afe_pulser_seq.sv
// Directed table-driven bench for afe_pulser_seq plus hand-written reset sequences.
module tb_afe_pulser_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    afe_pulser_seq_if u_if ();

    afe_pulser_seq #(.IO_RST_CYCLES(10), .MIN_PERIOD(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic        sg;
        logic        sp;
        logic [15:0] w;
        logic [23:0] p;
        logic [15:0] c;
        int          stop_after;
        int          perturb;
        int          max_cyc;
        int          e_trigs;
        int          e_space;
        logic [15:0] e_width;
        int          e_err;
        int          e_done;
        logic [15:0] e_pcnt;
    } vec_t;

    function automatic vec_t mk(string name, logic st, logic sg, logic sp,
                                logic [15:0] w, logic [23:0] p, logic [15:0] c,
                                int stop_after, int perturb, int max_cyc,
                                int e_trigs, int e_space, logic [15:0] e_width,
                                int e_err, int e_done, logic [15:0] e_pcnt);
        vec_t v;
        v.name = name; v.st = st; v.sg = sg; v.sp = sp;
        v.w = w; v.p = p; v.c = c;
        v.stop_after = stop_after; v.perturb = perturb; v.max_cyc = max_cyc;
        v.e_trigs = e_trigs; v.e_space = e_space; v.e_width = e_width;
        v.e_err = e_err; v.e_done = e_done; v.e_pcnt = e_pcnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors the IO_HOLD window after reset release; optionally pokes start inside it.
    task automatic hold_check(input string tag, input bit poke);
        int fall_k = -1;
        int n_trig = 0;
        int n_err  = 0;
        int n_done = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (fall_k < 0 && !u_if.io_rst) fall_k = k;
            if (u_if.trig) n_trig++;
            if (u_if.err)  n_err++;
            if (u_if.done) n_done++;
            if (poke) begin
                if (k == 3) begin
                    u_if.cfg_width = 16'd7; u_if.cfg_period = 24'd8; u_if.cfg_count = 16'd2;
                    u_if.start = 1'b1; u_if.single = 1'b1;
                end
                if (k == 4) begin
                    u_if.start = 1'b0; u_if.single = 1'b0;
                end
            end
        end
        chk({tag, " io_rst_fall_cycle"}, 32'(fall_k), 32'd10);
        chk({tag, " trigs_in_hold"}, 32'(n_trig), 32'd0);
        chk({tag, " err_in_hold"}, 32'(n_err), 32'd0);
        chk({tag, " done_in_hold"}, 32'(n_done), 32'd0);
        chk({tag, " busy_after_hold"}, 32'(u_if.busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int n_trig = 0;
        int n_err  = 0;
        int n_done = 0;
        int last_k = -1;
        int done_k = -1;
        u_if.cfg_width  = v.w;
        u_if.cfg_period = v.p;
        u_if.cfg_count  = v.c;
        u_if.start      = v.st;
        u_if.single     = v.sg;
        u_if.stop       = v.sp;
        tick();
        u_if.start = 1'b0; u_if.single = 1'b0; u_if.stop = 1'b0;
        for (int k = 0; k < v.max_cyc; k++) begin
            u_if.stop = 1'b0;
            if (v.perturb != 0) begin
                if (k == 5) begin
                    u_if.cfg_width = 16'd99; u_if.cfg_period = 24'd7; u_if.cfg_count = 16'd1;
                    u_if.start = 1'b1;
                end
                if (k == 6) begin u_if.start = 1'b0; u_if.single = 1'b1; end
                if (k == 7) u_if.single = 1'b0;
            end
            if (u_if.trig) begin
                if (n_trig == 0) chk({v.name, " first_trig_cycle"}, 32'(k), 32'd0);
                else             chk({v.name, " trig_spacing"}, 32'(k - last_k), 32'(v.e_space));
                chk({v.name, " width_at_trig"}, 32'(u_if.width), 32'(v.e_width));
                n_trig++;
                last_k = k;
                if (v.stop_after != 0 && n_trig == v.stop_after) u_if.stop = 1'b1;
            end
            if (u_if.err) n_err++;
            if (u_if.done) begin n_done++; done_k = k; end
            tick();
        end
        u_if.stop = 1'b0;
        chk({v.name, " trig_count"}, 32'(n_trig), 32'(v.e_trigs));
        chk({v.name, " err_cycles"}, 32'(n_err), 32'(v.e_err));
        chk({v.name, " done_cycles"}, 32'(n_done), 32'(v.e_done));
        chk({v.name, " pulse_cnt"}, 32'(u_if.pulse_cnt), 32'(v.e_pcnt));
        chk({v.name, " busy_end"}, 32'(u_if.busy), 32'd0);
        if (v.e_done != 0 && n_trig > 0)
            chk({v.name, " done_after_last_trig"}, 32'(done_k - last_k), 32'd2);
    endtask

    vec_t vecs[8];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        u_if.start = 1'b0; u_if.single = 1'b0; u_if.stop = 1'b0;
        u_if.cfg_width = '0; u_if.cfg_period = '0; u_if.cfg_count = '0;

        //            name           st sg sp  w       p       c     stp pt max trg spc wid    err dn pcnt
        vecs[0] = mk("burst3",       1, 0, 0, 16'd12, 24'd20, 16'd3, 0, 0, 60, 3, 20, 16'd12, 0, 1, 16'd3);
        vecs[1] = mk("cont_stop5",   1, 0, 0, 16'd9,  24'd2,  16'd0, 5, 0, 40, 5, 4,  16'd9,  0, 1, 16'd5);
        vecs[2] = mk("busy_perturb", 1, 0, 0, 16'd12, 24'd20, 16'd3, 0, 1, 60, 3, 20, 16'd12, 0, 1, 16'd3);
        vecs[3] = mk("single_w1",    0, 1, 0, 16'd1,  24'd10, 16'd7, 0, 0, 20, 1, 0,  16'd1,  0, 1, 16'd1);
        vecs[4] = mk("zero_width",   1, 0, 0, 16'd0,  24'd10, 16'd3, 0, 0, 10, 0, 0,  16'd0,  1, 0, 16'd1);
        vecs[5] = mk("start_stop",   1, 0, 1, 16'd5,  24'd6,  16'd2, 0, 0, 10, 0, 0,  16'd0,  0, 0, 16'd1);
        vecs[6] = mk("start_wins",   1, 1, 0, 16'd3,  24'd5,  16'd2, 0, 0, 20, 2, 5,  16'd3,  0, 1, 16'd2);
        vecs[7] = mk("single_zero",  0, 1, 0, 16'd0,  24'd5,  16'd4, 0, 0, 10, 0, 0,  16'd0,  1, 0, 16'd2);

        repeat (3) @(posedge clk);
        #1;
        chk("rst io_rst", 32'(u_if.io_rst), 32'd1);
        chk("rst trig", 32'(u_if.trig), 32'd0);
        chk("rst width", 32'(u_if.width), 32'd0);
        chk("rst busy", 32'(u_if.busy), 32'd1);
        chk("rst done", 32'(u_if.done), 32'd0);
        chk("rst err", 32'(u_if.err), 32'd0);
        chk("rst pulse_cnt", 32'(u_if.pulse_cnt), 32'd0);
        rst_n = 1'b1;
        hold_check("hold1", 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            repeat (2) tick();
        end

        // Reset asserted mid-WAIT of a continuous burst.
        u_if.cfg_width = 16'd5; u_if.cfg_period = 24'd20; u_if.cfg_count = 16'd0;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        chk("midwait first trig", 32'(u_if.trig), 32'd1);
        repeat (8) tick();
        chk("midwait busy before rst", 32'(u_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midwait io_rst", 32'(u_if.io_rst), 32'd1);
        chk("midwait trig", 32'(u_if.trig), 32'd0);
        chk("midwait width", 32'(u_if.width), 32'd0);
        chk("midwait pulse_cnt", 32'(u_if.pulse_cnt), 32'd0);
        chk("midwait done", 32'(u_if.done), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        hold_check("hold2", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
